// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction-fetch sequencer
// ST_LOAD exists only when IMEM_LOADER_EN is defined.
package imem_pkg;

  localparam int INSTR_WIDTH = 16;
  localparam int BYTE_WIDTH  = 8;
  localparam int PC_STEP     = 2;

  localparam logic [INSTR_WIDTH-1:0] HALT_OPCODE_DEFAULT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
`ifdef IMEM_LOADER_EN
    ,
    ST_LOAD  = 2'd3
`endif
  } state_t;

endpackage

// File: rtl/imem_load_seq.sv
// rtl/imem_load_seq.sv - byte-load counter and write strobe for instruction memory preload
// Used by imem_fetch_ctrl only when IMEM_LOADER_EN is defined.
module imem_load_seq
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_BYTES  = 256
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Enable,
  input  logic                  i_Load_Valid,
  input  logic [BYTE_WIDTH-1:0] i_Load_Byte,
  input  logic                  i_Load_Last,
  output logic                  o_Load_Ready,
  output logic                  o_Accept,
  output logic                  o_Done,
  output logic                  o_Wr_En,
  output logic [BYTE_WIDTH-1:0] o_Wr_Data,
  output logic [ADDR_WIDTH-1:0] o_Wr_Addr
);

  localparam logic [ADDR_WIDTH-1:0] CNT_MASK = ADDR_WIDTH'(MEM_BYTES - 1);

  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] cnt_d;

  assign o_Load_Ready = i_Enable;
  assign o_Accept     = i_Load_Valid && i_Enable;
  assign o_Done       = o_Accept && i_Load_Last;
  assign o_Wr_En      = o_Accept;
  assign o_Wr_Data    = i_Load_Byte;
  assign o_Wr_Addr    = cnt_q;

  // Counter returns to 0 after the last byte so every load session starts at address 0.
  always_comb begin
    cnt_d = cnt_q;
    if (!i_Enable) begin
      cnt_d = '0;
    end else if (o_Accept) begin
      cnt_d = i_Load_Last ? '0 : ((cnt_q + ADDR_WIDTH'(1)) & CNT_MASK);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - PC sequencer and IF/ID register for byte-wide big-endian instruction memory
// Optional byte preload path enabled by defining IMEM_LOADER_EN.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int                      ADDR_WIDTH  = 16,
  parameter int                      MEM_BYTES   = 256,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Start,
  input  logic                   i_Stall,
  input  logic                   i_Redirect,
  input  logic [ADDR_WIDTH-1:0]  i_Redirect_Target,
  output logic [ADDR_WIDTH-1:0]  o_Imem_Address,
  input  logic [INSTR_WIDTH-1:0] i_Imem_Instruction,
  output logic [INSTR_WIDTH-1:0] o_Instruction,
  output logic [ADDR_WIDTH-1:0]  o_PC,
  output logic                   o_Valid,
`ifdef IMEM_LOADER_EN
  input  logic                   i_Load_Valid,
  input  logic [BYTE_WIDTH-1:0]  i_Load_Byte,
  input  logic                   i_Load_Last,
  output logic                   o_Load_Ready,
  output logic                   o_Imem_Wr_En,
  output logic [BYTE_WIDTH-1:0]  o_Imem_Wr_Data,
`endif
  output logic                   o_Busy
);

  localparam logic [ADDR_WIDTH-1:0] PC_MASK    = ADDR_WIDTH'(MEM_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = PC_MASK & ~ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(PC_STEP);

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]  opc_q, opc_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;

  logic                   advance;
  logic [ADDR_WIDTH-1:0]  redirect_pc;
  logic [ADDR_WIDTH-1:0]  start_pc;
  logic [ADDR_WIDTH-1:0]  next_pc;

  assign advance     = !(valid_q && i_Stall);
  assign redirect_pc = i_Redirect_Target & ALIGN_MASK;
  assign start_pc    = RESET_PC & ALIGN_MASK;
  assign next_pc     = (pc_q + STEP) & PC_MASK;

`ifdef IMEM_LOADER_EN
  logic                  load_sel;
  logic                  load_accept;
  logic                  load_done;
  logic [ADDR_WIDTH-1:0] load_addr;

  imem_load_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_BYTES  (MEM_BYTES)
  ) u_load_seq (
    .i_Clk        (i_Clk),
    .i_Reset      (i_Reset),
    .i_Enable     ((state_q == ST_IDLE) || (state_q == ST_LOAD)),
    .i_Load_Valid (i_Load_Valid),
    .i_Load_Byte  (i_Load_Byte),
    .i_Load_Last  (i_Load_Last),
    .o_Load_Ready (o_Load_Ready),
    .o_Accept     (load_accept),
    .o_Done       (load_done),
    .o_Wr_En      (o_Imem_Wr_En),
    .o_Wr_Data    (o_Imem_Wr_Data),
    .o_Wr_Addr    (load_addr)
  );

  // A byte offered in IDLE is already accepted, so the address must follow the counter then too.
  assign load_sel       = (state_q == ST_LOAD) || ((state_q == ST_IDLE) && i_Load_Valid);
  assign o_Imem_Address = load_sel ? load_addr : pc_q;
`else
  assign o_Imem_Address = pc_q;
`endif

  assign o_Instruction = instr_q;
  assign o_PC          = opc_q;
  assign o_Valid       = valid_q;
  assign o_Busy        = busy_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    valid_d = valid_q;

    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
`ifdef IMEM_LOADER_EN
        if (load_accept) begin
          state_d = load_done ? ST_IDLE : ST_LOAD;
        end else if (i_Start) begin
          state_d = ST_FETCH;
          pc_d    = start_pc;
        end
`else
        if (i_Start) begin
          state_d = ST_FETCH;
          pc_d    = start_pc;
        end
`endif
      end

      ST_FETCH: begin
        if (i_Redirect) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
        end else if (advance) begin
          instr_d = i_Imem_Instruction;
          opc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = next_pc;
          if (i_Imem_Instruction == HALT_OPCODE) begin
            state_d = ST_HALT;
          end
        end
      end

      // The halt word may be speculative, so a redirect reopens fetching.
      ST_HALT: begin
        if (i_Redirect) begin
          state_d = ST_FETCH;
          pc_d    = redirect_pc;
          valid_d = 1'b0;
        end else if (i_Start) begin
          state_d = ST_FETCH;
          pc_d    = start_pc;
          valid_d = 1'b0;
        end else if (!i_Stall) begin
          valid_d = 1'b0;
        end
      end

`ifdef IMEM_LOADER_EN
      ST_LOAD: begin
        valid_d = 1'b0;
        if (load_done) begin
          state_d = ST_IDLE;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase

`ifdef IMEM_LOADER_EN
    busy_d = (state_d == ST_FETCH) || (state_d == ST_LOAD);
`else
    busy_d = (state_d == ST_FETCH);
`endif
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC & ALIGN_MASK;
      instr_q <= '0;
      opc_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - directed self-checking bench for imem_fetch_ctrl
// Loader scenario compiled in when IMEM_LOADER_EN is defined.
module tb_imem_fetch_ctrl;

  logic        i_Clk;
  logic        i_Reset;
  logic        i_Start;
  logic        i_Stall;
  logic        i_Redirect;
  logic [15:0] i_Redirect_Target;
  logic [15:0] o_Imem_Address;
  logic [15:0] i_Imem_Instruction;
  logic [15:0] o_Instruction;
  logic [15:0] o_PC;
  logic        o_Valid;
  logic        o_Busy;
`ifdef IMEM_LOADER_EN
  logic        i_Load_Valid;
  logic [7:0]  i_Load_Byte;
  logic        i_Load_Last;
  logic        o_Load_Ready;
  logic        o_Imem_Wr_En;
  logic [7:0]  o_Imem_Wr_Data;
`endif

  int n_checks;
  int n_fail;

  logic [7:0] mem [0:255];
  logic [7:0] addr_hi;
  logic [7:0] addr_lo;

  assign addr_hi = o_Imem_Address[7:0];
  assign addr_lo = addr_hi + 8'd1;
  assign i_Imem_Instruction = {mem[addr_hi], mem[addr_lo]};

  imem_fetch_ctrl dut (
    .i_Clk              (i_Clk),
    .i_Reset            (i_Reset),
    .i_Start            (i_Start),
    .i_Stall            (i_Stall),
    .i_Redirect         (i_Redirect),
    .i_Redirect_Target  (i_Redirect_Target),
    .o_Imem_Address     (o_Imem_Address),
    .i_Imem_Instruction (i_Imem_Instruction),
    .o_Instruction      (o_Instruction),
    .o_PC               (o_PC),
    .o_Valid            (o_Valid),
`ifdef IMEM_LOADER_EN
    .i_Load_Valid       (i_Load_Valid),
    .i_Load_Byte        (i_Load_Byte),
    .i_Load_Last        (i_Load_Last),
    .o_Load_Ready       (o_Load_Ready),
    .o_Imem_Wr_En       (o_Imem_Wr_En),
    .o_Imem_Wr_Data     (o_Imem_Wr_Data),
`endif
    .o_Busy             (o_Busy)
  );

  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

`ifdef IMEM_LOADER_EN
  always @(posedge i_Clk) begin
    if (o_Imem_Wr_En) mem[o_Imem_Address[7:0]] = o_Imem_Wr_Data;
  end
`endif

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic test_reset();
    i_Reset = 1'b1;
    tick();
    tick();
    n_checks++; if (o_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", o_Valid); end
    n_checks++; if (o_Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", o_Busy); end
    n_checks++; if (o_PC !== 16'h0000) begin n_fail++; $display("FAIL reset_pc got %h exp 0000", o_PC); end
    n_checks++; if (o_Instruction !== 16'h0000) begin n_fail++; $display("FAIL reset_instr got %h exp 0000", o_Instruction); end
    n_checks++; if (o_Imem_Address !== 16'h0000) begin n_fail++; $display("FAIL reset_addr got %h exp 0000", o_Imem_Address); end
    i_Reset = 1'b0;
    tick();
    n_checks++; if (o_Busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b exp 0", o_Busy); end
  endtask

  task automatic test_fetch();
    logic [15:0] exp_pc [3];
    logic [15:0] exp_in [3];
    exp_pc = '{16'h0000, 16'h0002, 16'h0004};
    exp_in = '{16'h1234, 16'h5678, 16'h0405};
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    n_checks++; if (o_Busy !== 1'b1) begin n_fail++; $display("FAIL start_busy got %b exp 1", o_Busy); end
    n_checks++; if (o_Valid !== 1'b0) begin n_fail++; $display("FAIL start_valid got %b exp 0", o_Valid); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (o_Valid !== 1'b1) begin n_fail++; $display("FAIL fetch_valid[%0d] got %b exp 1", k, o_Valid); end
      n_checks++; if (o_PC !== exp_pc[k]) begin n_fail++; $display("FAIL fetch_pc[%0d] got %h exp %h", k, o_PC, exp_pc[k]); end
      n_checks++; if (o_Instruction !== exp_in[k]) begin n_fail++; $display("FAIL fetch_instr[%0d] got %h exp %h", k, o_Instruction, exp_in[k]); end
    end
  endtask

  task automatic test_stall();
    i_Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (o_PC !== 16'h0004 || o_Instruction !== 16'h0405 || o_Valid !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold[%0d] got pc=%h instr=%h v=%b exp pc=0004 instr=0405 v=1", k, o_PC, o_Instruction, o_Valid);
      end
    end
    i_Stall = 1'b0;
    tick();
    n_checks++; if (o_PC !== 16'h0006 || o_Instruction !== 16'h0607) begin n_fail++; $display("FAIL stall_resume got pc=%h instr=%h exp pc=0006 instr=0607", o_PC, o_Instruction); end
    tick();
    n_checks++; if (o_PC !== 16'h0008 || o_Instruction !== 16'h0809) begin n_fail++; $display("FAIL stall_next got pc=%h instr=%h exp pc=0008 instr=0809", o_PC, o_Instruction); end
  endtask

  task automatic test_redirect();
    i_Stall = 1'b1;
    i_Redirect = 1'b1;
    i_Redirect_Target = 16'h0031;
    tick();
    i_Redirect = 1'b0;
    i_Stall = 1'b0;
    n_checks++; if (o_Valid !== 1'b0) begin n_fail++; $display("FAIL redir_squash got %b exp 0", o_Valid); end
    n_checks++; if (o_Imem_Address !== 16'h0030) begin n_fail++; $display("FAIL redir_addr got %h exp 0030", o_Imem_Address); end
    tick();
    n_checks++; if (o_Valid !== 1'b1 || o_PC !== 16'h0030 || o_Instruction !== 16'h3031) begin
      n_fail++; $display("FAIL redir_issue got v=%b pc=%h instr=%h exp v=1 pc=0030 instr=3031", o_Valid, o_PC, o_Instruction);
    end
  endtask

  task automatic test_wrap();
    i_Redirect = 1'b1;
    i_Redirect_Target = 16'h00FC;
    tick();
    i_Redirect = 1'b0;
    tick();
    n_checks++; if (o_PC !== 16'h00FC || o_Instruction !== 16'hFCFD) begin n_fail++; $display("FAIL wrap_fc got pc=%h instr=%h exp pc=00fc instr=fcfd", o_PC, o_Instruction); end
    tick();
    n_checks++; if (o_PC !== 16'h00FE || o_Instruction !== 16'hFEFF || o_Valid !== 1'b1) begin n_fail++; $display("FAIL wrap_fe got pc=%h instr=%h v=%b exp pc=00fe instr=feff v=1", o_PC, o_Instruction, o_Valid); end
    tick();
    n_checks++; if (o_PC !== 16'h0000 || o_Instruction !== 16'h1234) begin n_fail++; $display("FAIL wrap_zero got pc=%h instr=%h exp pc=0000 instr=1234", o_PC, o_Instruction); end
    n_checks++; if (o_Imem_Address !== 16'h0002) begin n_fail++; $display("FAIL wrap_addr got %h exp 0002", o_Imem_Address); end
  endtask

  task automatic test_halt();
    mem[8] = 8'hFF;
    mem[9] = 8'hFF;
    i_Redirect = 1'b1;
    i_Redirect_Target = 16'h0004;
    tick();
    i_Redirect = 1'b0;
    tick();
    tick();
    tick();
    n_checks++; if (o_PC !== 16'h0008 || o_Instruction !== 16'hFFFF || o_Valid !== 1'b1) begin
      n_fail++; $display("FAIL halt_issue got pc=%h instr=%h v=%b exp pc=0008 instr=ffff v=1", o_PC, o_Instruction, o_Valid);
    end
    n_checks++; if (o_Busy !== 1'b0) begin n_fail++; $display("FAIL halt_busy got %b exp 0", o_Busy); end
    tick();
    n_checks++; if (o_Valid !== 1'b0) begin n_fail++; $display("FAIL halt_clear got %b exp 0", o_Valid); end
    tick();
    n_checks++; if (o_Valid !== 1'b0 || o_PC !== 16'h0008) begin n_fail++; $display("FAIL halt_stay got v=%b pc=%h exp v=0 pc=0008", o_Valid, o_PC); end
    i_Redirect = 1'b1;
    i_Redirect_Target = 16'h0010;
    tick();
    i_Redirect = 1'b0;
    n_checks++; if (o_Busy !== 1'b1 || o_Valid !== 1'b0) begin n_fail++; $display("FAIL halt_cancel got busy=%b v=%b exp busy=1 v=0", o_Busy, o_Valid); end
    tick();
    n_checks++; if (o_PC !== 16'h0010 || o_Instruction !== 16'h1011 || o_Valid !== 1'b1) begin
      n_fail++; $display("FAIL halt_resume got pc=%h instr=%h v=%b exp pc=0010 instr=1011 v=1", o_PC, o_Instruction, o_Valid);
    end
    mem[8] = 8'h08;
    mem[9] = 8'h09;
  endtask

  task automatic test_start_vs_redirect();
    i_Start = 1'b1;
    i_Redirect = 1'b1;
    i_Redirect_Target = 16'h0021;
    tick();
    i_Start = 1'b0;
    i_Redirect = 1'b0;
    tick();
    n_checks++; if (o_PC !== 16'h0020 || o_Instruction !== 16'h2021) begin n_fail++; $display("FAIL start_ignored got pc=%h instr=%h exp pc=0020 instr=2021", o_PC, o_Instruction); end
  endtask

  task automatic test_reset_mid_fetch();
    @(posedge i_Clk);
    #2;
    i_Reset = 1'b1;
    #1;
    n_checks++; if (o_Valid !== 1'b0 || o_Busy !== 1'b0) begin n_fail++; $display("FAIL async_reset got v=%b busy=%b exp v=0 busy=0", o_Valid, o_Busy); end
    n_checks++; if (o_PC !== 16'h0000 || o_Instruction !== 16'h0000 || o_Imem_Address !== 16'h0000) begin
      n_fail++; $display("FAIL async_reset_regs got pc=%h instr=%h addr=%h exp 0000", o_PC, o_Instruction, o_Imem_Address);
    end
    tick();
    i_Reset = 1'b0;
    tick();
    n_checks++; if (o_Valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid got %b exp 0", o_Valid); end
  endtask

`ifdef IMEM_LOADER_EN
  task automatic test_loader();
    logic [7:0] bytes [4];
    bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    for (int k = 0; k < 4; k++) begin
      i_Load_Valid = 1'b1;
      i_Load_Byte  = bytes[k];
      i_Load_Last  = (k == 3);
      #1;
      n_checks++; if (o_Imem_Wr_En !== 1'b1 || o_Load_Ready !== 1'b1 || o_Imem_Address !== 16'(k)) begin
        n_fail++; $display("FAIL load_wr[%0d] got en=%b rdy=%b addr=%h exp en=1 rdy=1 addr=%h", k, o_Imem_Wr_En, o_Load_Ready, o_Imem_Address, 16'(k));
      end
      tick();
    end
    i_Load_Valid = 1'b0;
    i_Load_Last  = 1'b0;
    n_checks++; if (o_Busy !== 1'b0 || o_Load_Ready !== 1'b1) begin n_fail++; $display("FAIL load_idle got busy=%b rdy=%b exp busy=0 rdy=1", o_Busy, o_Load_Ready); end
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    n_checks++; if (o_Load_Ready !== 1'b0) begin n_fail++; $display("FAIL load_ready_fetch got %b exp 0", o_Load_Ready); end
    tick();
    n_checks++; if (o_PC !== 16'h0000 || o_Instruction !== 16'hAABB) begin n_fail++; $display("FAIL load_fetch0 got pc=%h instr=%h exp pc=0000 instr=aabb", o_PC, o_Instruction); end
    tick();
    n_checks++; if (o_PC !== 16'h0002 || o_Instruction !== 16'hCCDD) begin n_fail++; $display("FAIL load_fetch1 got pc=%h instr=%h exp pc=0002 instr=ccdd", o_PC, o_Instruction); end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail = 0;
    for (int i = 0; i < 256; i++) mem[i] = i[7:0];
    mem[0] = 8'h12;
    mem[1] = 8'h34;
    mem[2] = 8'h56;
    mem[3] = 8'h78;
    i_Reset = 1'b1;
    i_Start = 1'b0;
    i_Stall = 1'b0;
    i_Redirect = 1'b0;
    i_Redirect_Target = 16'h0000;
`ifdef IMEM_LOADER_EN
    i_Load_Valid = 1'b0;
    i_Load_Byte = 8'h00;
    i_Load_Last = 1'b0;
`endif
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_start_vs_redirect();
    test_reset_mid_fetch();
`ifdef IMEM_LOADER_EN
    test_loader();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
